// File: rtl/iob_bus_arbiter.sv
// Round-robin arbiter sharing one IOb slave port between N_MASTERS IOb masters.
// One transaction in flight; grant held until write acceptance or read response.
module iob_bus_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_MASTERS = 2
) (
  input  logic                            clk_i,
  input  logic                            cke_i,
  input  logic                            rst_n_i,
  input  logic [N_MASTERS-1:0]            m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb_i,
  output logic [N_MASTERS-1:0]            m_ready_o,
  output logic [N_MASTERS-1:0]            m_rvalid_o,
  output logic [DATA_W-1:0]               m_rdata_o,
  output logic                            s_avalid_o,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  output logic [DATA_W/8-1:0]             s_wstrb_o,
  input  logic                            s_ready_i,
  input  logic                            s_rvalid_i,
  input  logic [DATA_W-1:0]               s_rdata_i,
  output logic [N_MASTERS-1:0]            grant_o,
  output logic                            busy_o,
  output logic                            stray_rvalid_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned CAND_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     gidx_inc;
  logic [IDX_W-1:0]     pick;
  logic                 found;
  logic [CAND_W-1:0]    cand;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic                 busy_q;
  logic                 stray_q, stray_d;

  logic [ADDR_W-1:0]    addr_arr  [N_MASTERS];
  logic [DATA_W-1:0]    wdata_arr [N_MASTERS];
  logic [STRB_W-1:0]    wstrb_arr [N_MASTERS];

  // Unpack the flat per-master request buses
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = m_addr_i[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = m_wdata_i[i*DATA_W +: DATA_W];
    assign wstrb_arr[i] = m_wstrb_i[i*STRB_W +: STRB_W];
  end

  // Pointer to the master after the current owner, wrapping for any N_MASTERS
  assign gidx_inc = (gidx_q == IDX_W'(N_MASTERS - 1)) ? '0 : gidx_q + IDX_W'(1);

  // Round-robin search starting at ptr_q
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      cand = CAND_W'(ptr_q) + CAND_W'(i);
      if (cand >= CAND_W'(N_MASTERS)) begin
        cand = cand - CAND_W'(N_MASTERS);
      end
      if (!found && m_avalid_i[IDX_W'(cand)]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
  end

  // Next-state and slave/master routing
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    s_avalid_o = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    stray_d    = s_rvalid_i && (state_q != WAIT_RESP);

    unique case (state_q)
      IDLE: begin
        if (found) begin
          gidx_d  = pick;
          grant_d = N_MASTERS'(1) << pick;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        s_avalid_o        = m_avalid_i[gidx_q];
        s_addr_o          = addr_arr[gidx_q];
        s_wdata_o         = wdata_arr[gidx_q];
        s_wstrb_o         = wstrb_arr[gidx_q];
        m_ready_o[gidx_q] = s_ready_i;
        // Withdrawn request: nothing was issued, so the pointer stays put
        if (!m_avalid_i[gidx_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (s_ready_i) begin
          if (wstrb_arr[gidx_q] != '0) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = gidx_inc;
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end

      WAIT_RESP: begin
        m_rvalid_o[gidx_q] = s_rvalid_i;
        if (s_rvalid_i) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gidx_inc;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and registered status outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      stray_q <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      busy_q  <= (state_d != IDLE);
      stray_q <= stray_d;
    end
  end

  assign m_rdata_o      = s_rdata_i;
  assign grant_o        = grant_q;
  assign busy_o         = busy_q;
  assign stray_rvalid_o = stray_q;

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Directed bench for iob_bus_arbiter: per-cycle vector table on a 2-master
// instance, plus round-robin fairness and 3-master wrap-around sequences.
module tb_iob_bus_arbiter;

  localparam logic [31:0] M0_ADDR  = 32'h0000_0100;
  localparam logic [31:0] M1_ADDR  = 32'h0000_0200;
  localparam logic [31:0] M0_WDATA = 32'h1111_1111;
  localparam logic [31:0] M1_WDATA = 32'h5A5A_5A5A;
  localparam logic [31:0] RDATA    = 32'hDEAD_BEEF;
  localparam int          NVEC     = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        cke, rst_n;

  // Two-master instance
  logic [1:0]  m_avalid;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_ready, m_rvalid;
  logic [31:0] m_rdata;
  logic        s_avalid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready, s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        busy, stray;

  // Three-master instance
  logic [2:0]  m_avalid3;
  logic [95:0] m_addr3, m_wdata3;
  logic [11:0] m_wstrb3;
  logic [2:0]  m_ready3, m_rvalid3;
  logic [31:0] m_rdata3;
  logic        s_avalid3;
  logic [31:0] s_addr3, s_wdata3;
  logic [3:0]  s_wstrb3;
  logic        s_ready3, s_rvalid3;
  logic [31:0] s_rdata3;
  logic [2:0]  grant3;
  logic        busy3, stray3;

  iob_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .N_MASTERS(2)) u_dut (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n),
    .m_avalid_i(m_avalid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
    .m_ready_o(m_ready), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_ready_i(s_ready), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .grant_o(grant), .busy_o(busy), .stray_rvalid_o(stray)
  );

  iob_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .N_MASTERS(3)) u_dut3 (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n),
    .m_avalid_i(m_avalid3), .m_addr_i(m_addr3), .m_wdata_i(m_wdata3), .m_wstrb_i(m_wstrb3),
    .m_ready_o(m_ready3), .m_rvalid_o(m_rvalid3), .m_rdata_o(m_rdata3),
    .s_avalid_o(s_avalid3), .s_addr_o(s_addr3), .s_wdata_o(s_wdata3), .s_wstrb_o(s_wstrb3),
    .s_ready_i(s_ready3), .s_rvalid_i(s_rvalid3), .s_rdata_i(s_rdata3),
    .grant_o(grant3), .busy_o(busy3), .stray_rvalid_o(stray3)
  );

  typedef struct {
    logic       rst_n;
    logic       cke;
    logic [1:0] av;
    logic [3:0] w0;
    logic [3:0] w1;
    logic       rdy;
    logic       rv;
    int         sel;    // which master's fields appear on s_*: 0 none, 1 m0, 2 m1
    logic       sav;
    logic [1:0] mrdy;
    logic [1:0] mrv;
    logic [1:0] gnt;
    logic       busy;
    logic       stray;
  } vec_t;

  vec_t tv [NVEC];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input int r, input int c, input int av, input int w0, input int w1,
                              input int rdy, input int rv, input int sel, input int sav,
                              input int mrdy, input int mrv, input int gnt, input int bsy,
                              input int sty);
    vec_t v;
    v.rst_n = 1'(r);   v.cke  = 1'(c);    v.av  = 2'(av);  v.w0  = 4'(w0);
    v.w1    = 4'(w1);  v.rdy  = 1'(rdy);  v.rv  = 1'(rv);  v.sel = sel;
    v.sav   = 1'(sav); v.mrdy = 2'(mrdy); v.mrv = 2'(mrv); v.gnt = 2'(gnt);
    v.busy  = 1'(bsy); v.stray = 1'(sty);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  logic [1:0]  exp_g;
  int          cnt0, cnt1;

  initial begin
    //         rst cke av    w0  w1  rdy rv | sel sav mrdy  mrv   gnt   bsy sty
    // single read by master 0
    tv[0]  = mk(1, 1, 'b00, 0, 0,   0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    tv[1]  = mk(1, 1, 'b01, 0, 0,   0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    tv[2]  = mk(1, 1, 'b01, 0, 0,   0, 0,   1, 1, 'b00, 'b00, 'b01, 1, 0);
    tv[3]  = mk(1, 1, 'b01, 0, 0,   1, 0,   1, 1, 'b01, 'b00, 'b01, 1, 0);
    tv[4]  = mk(1, 1, 'b00, 0, 0,   0, 0,   0, 0, 'b00, 'b00, 'b01, 1, 0);
    tv[5]  = mk(1, 1, 'b00, 0, 0,   0, 1,   0, 0, 'b00, 'b01, 'b01, 1, 0);
    tv[6]  = mk(1, 1, 'b00, 0, 0,   0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    // ptr=1: master1 write wins, then master0 read; stray rvalid in IDLE
    tv[7]  = mk(1, 1, 'b11, 0, 'hF, 0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    tv[8]  = mk(1, 1, 'b11, 0, 'hF, 1, 0,   2, 1, 'b10, 'b00, 'b10, 1, 0);
    tv[9]  = mk(1, 1, 'b01, 0, 'hF, 0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    tv[10] = mk(1, 1, 'b01, 0, 'hF, 1, 0,   1, 1, 'b01, 'b00, 'b01, 1, 0);
    tv[11] = mk(1, 1, 'b00, 0, 'hF, 0, 1,   0, 0, 'b00, 'b01, 'b01, 1, 0);
    tv[12] = mk(1, 1, 'b00, 0, 0,   0, 1,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    tv[13] = mk(1, 1, 'b00, 0, 0,   0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 1);
    tv[14] = mk(1, 1, 'b00, 0, 0,   0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    // ptr=1: master1 withdraws in ACCESS, ptr must stay 1
    tv[15] = mk(1, 1, 'b10, 0, 'hF, 0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    tv[16] = mk(1, 1, 'b00, 0, 'hF, 0, 0,   2, 0, 'b00, 'b00, 'b10, 1, 0);
    tv[17] = mk(1, 1, 'b11, 0, 'hF, 0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    tv[18] = mk(1, 1, 'b11, 0, 'hF, 0, 0,   2, 1, 'b00, 'b00, 'b10, 1, 0);
    tv[19] = mk(1, 1, 'b11, 0, 'hF, 1, 0,   2, 1, 'b10, 'b00, 'b10, 1, 0);
    // master0 read, reset in WAIT_RESP, late rvalid becomes stray
    tv[20] = mk(1, 1, 'b01, 0, 'hF, 0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    tv[21] = mk(1, 1, 'b01, 0, 'hF, 0, 0,   1, 1, 'b00, 'b00, 'b01, 1, 0);
    tv[22] = mk(1, 1, 'b01, 0, 'hF, 1, 0,   1, 1, 'b01, 'b00, 'b01, 1, 0);
    tv[23] = mk(0, 1, 'b00, 0, 'hF, 0, 0,   0, 0, 'b00, 'b00, 'b01, 1, 0);
    tv[24] = mk(1, 1, 'b00, 0, 0,   0, 1,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    tv[25] = mk(1, 1, 'b00, 0, 0,   0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 1);
    tv[26] = mk(1, 1, 'b00, 0, 0,   0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    // clock enable low freezes IDLE and ACCESS
    tv[27] = mk(1, 0, 'b10, 0, 'hF, 0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    tv[28] = mk(1, 1, 'b10, 0, 'hF, 0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);
    tv[29] = mk(1, 0, 'b10, 0, 'hF, 1, 0,   2, 1, 'b10, 'b00, 'b10, 1, 0);
    tv[30] = mk(1, 1, 'b10, 0, 'hF, 1, 0,   2, 1, 'b10, 'b00, 'b10, 1, 0);
    tv[31] = mk(1, 1, 'b00, 0, 0,   0, 0,   0, 0, 'b00, 'b00, 'b00, 0, 0);

    m_addr    = {M1_ADDR, M0_ADDR};
    m_wdata   = {M1_WDATA, M0_WDATA};
    m_wstrb   = '0;
    m_avalid  = '0;
    s_ready   = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = RDATA;
    m_addr3   = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    m_wdata3  = {3{32'hCAFE_0000}};
    m_wstrb3  = 12'hFFF;
    m_avalid3 = '0;
    s_ready3  = 1'b0;
    s_rvalid3 = 1'b0;
    s_rdata3  = '0;
    cke       = 1'b1;
    rst_n     = 1'b0;
    step();
    step();

    for (int i = 0; i < NVEC; i++) begin
      rst_n    = tv[i].rst_n;
      cke      = tv[i].cke;
      m_avalid = tv[i].av;
      m_wstrb  = {tv[i].w1, tv[i].w0};
      s_ready  = tv[i].rdy;
      s_rvalid = tv[i].rv;
      case (tv[i].sel)
        1:       begin e_addr = M0_ADDR; e_wdata = M0_WDATA; e_wstrb = tv[i].w0; end
        2:       begin e_addr = M1_ADDR; e_wdata = M1_WDATA; e_wstrb = tv[i].w1; end
        default: begin e_addr = '0;      e_wdata = '0;       e_wstrb = '0;       end
      endcase
      #2;
      chk("s_avalid", i, 32'(s_avalid), 32'(tv[i].sav));
      chk("s_addr",   i, s_addr,        e_addr);
      chk("s_wdata",  i, s_wdata,       e_wdata);
      chk("s_wstrb",  i, 32'(s_wstrb),  32'(e_wstrb));
      chk("m_ready",  i, 32'(m_ready),  32'(tv[i].mrdy));
      chk("m_rvalid", i, 32'(m_rvalid), 32'(tv[i].mrv));
      chk("grant",    i, 32'(grant),    32'(tv[i].gnt));
      chk("busy",     i, 32'(busy),     32'(tv[i].busy));
      chk("stray",    i, 32'(stray),    32'(tv[i].stray));
      if (tv[i].mrv != 2'b00) chk("m_rdata", i, m_rdata, RDATA);
      step();
    end

    // Continuous writes from both masters with an always-ready slave
    rst_n    = 1'b1;
    cke      = 1'b1;
    m_avalid = 2'b11;
    m_wstrb  = 8'hFF;
    s_ready  = 1'b1;
    s_rvalid = 1'b0;
    exp_g    = 2'b01;
    cnt0     = 0;
    cnt1     = 0;
    for (int t = 0; t < 100; t++) begin
      step();
      #2;
      chk("rr_grant", t, 32'(grant), 32'(exp_g));
      if (grant == 2'b01) cnt0++;
      else if (grant == 2'b10) cnt1++;
      exp_g = {exp_g[0], exp_g[1]};
      step();
    end
    chk("rr_count_m0", 0, 32'(cnt0), 32'd50);
    chk("rr_count_m1", 0, 32'(cnt1), 32'd50);
    m_avalid = 2'b00;
    s_ready  = 1'b0;
    step();

    // Three masters: master1 write moves ptr to 2, then 0 wins by wrap-around
    m_avalid3 = 3'b010;
    s_ready3  = 1'b1;
    #2 chk("n3_idle", 0, 32'(grant3), 32'd0);
    step();
    #2 chk("n3_first", 1, 32'(grant3), 32'(3'b010));
    chk("n3_addr", 1, s_addr3, 32'h0000_2000);
    step();
    m_avalid3 = 3'b011;
    #2 chk("n3_idle", 2, 32'(grant3), 32'd0);
    step();
    #2 chk("n3_wrap", 3, 32'(grant3), 32'(3'b001));
    chk("n3_addr", 3, s_addr3, 32'h0000_1000);
    step();
    m_avalid3 = 3'b010;
    #2 chk("n3_idle", 4, 32'(grant3), 32'd0);
    step();
    #2 chk("n3_next", 5, 32'(grant3), 32'(3'b010));
    chk("n3_addr", 5, s_addr3, 32'h0000_2000);
    step();
    m_avalid3 = 3'b000;
    s_ready3  = 1'b0;
    #2 chk("n3_done", 6, 32'(grant3), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
